cdc_dst_reg_bank: RTL and testbench
===================================

// Module: cdc_dst_reg_bank
// PURPOSE
// - Register-bank slave in one bus_cdc destination clock domain, fed by one cpubus_o[i] channel.
// - Decodes single-cycle access pulses (address/data/we are zero outside a pulse).
// - Provides RW control registers, sticky W1C event bits and a 64-bit timestamp counter.
// - Registered read data: valid exactly 1 clk after the read pulse, as bus_cdc samples it.
// PARAMETERS
// - BaseAddress   32'h0000_9000  first address of window; must be nonzero (address 0 = idle bus)
// - AddressWidth  32             bus address width
// - DataWidth     32             bus data width; also width of each register
// - NumRwRegs     4              number of RW control registers (1..16)
// - NumEvents     8              sticky event bits in status register (1..DataWidth)
// PORTS
// - clk_i          in   1                       destination-domain clock (cdc_clks_i[i])
// - reset_n_i      in   1                       async active-low reset; assert async, deassert sync to clk_i
// - bus_we_i       in   1                       write enable, valid during pulse only
// - bus_address_i  in   AddressWidth            access address; 0 when idle
// - bus_data_i     in   DataWidth               write data
// - bus_data_o     out  DataWidth               registered read data
// - event_i        in   NumEvents               event inputs; any cycle high sets sticky bit
// - rw_regs_o      out  NumRwRegs*DataWidth     RW register contents, reg k at [k*DataWidth +: DataWidth]
// - wr_strobe_o    out  NumRwRegs               1-clk pulse, cycle after write to RW reg k
// - event_flags_o  out  NumEvents               current sticky event bits
// BEHAVIOUR
// - Offset = bus_address_i - BaseAddress. Access when BaseAddress <= address < BaseAddress+NumRwRegs+3.
// - Map: offset 0..NumRwRegs-1 = RW regs.
// - Map: NumRwRegs = STATUS; NumRwRegs+1 = TS_LO; NumRwRegs+2 = TS_HI.
// - Address outside window: no effect; bus_data_o holds its value.
// - Reads: bus_data_o <= selected value on the pulse edge; valid next cycle; held until next in-window read.
// - STATUS read: {zero-extend, flags}. TS_LO read: returns counter[31:0] and snapshots counter[63:32] into shadow.
// - TS_HI read: returns shadow, not live counter; shadow unchanged by TS_HI read.
// - RW write: reg <= bus_data_i; wr_strobe_o[k] high exactly 1 cycle following the write.
// - STATUS write: W1C; flags <= (flags & ~data[NumEvents-1:0]) | event_i. Set wins over clear in same cycle.
// - Flags otherwise: flags <= flags | event_i each cycle.
// - TS_LO write: counter <= 0 (data ignored); shadow unchanged. TS_HI write: ignored.
// - Counter: free-running 64-bit, +1 per clk_i; wraps 2^64-1 -> 0, no flag.
// - Counter write-clear coincident with increment: clear wins (counter = 0 next cycle).
// - Width: DataWidth < 32 truncates TS values to [DataWidth-1:0] per half.
// - Reset (any time, incl. mid-access): bus_data_o=0, rw regs=0, wr_strobe_o=0, flags=0, counter=0, shadow=0.
// - Reset: access in progress is dropped; first pulse after deassert is decoded normally.
// - Back-to-back pulses on consecutive cycles are each decoded; last read determines bus_data_o.
// CONFIGURATION
// - CDC_DST_REG_BANK_TIMESTAMP_EN defined: counter, shadow, TS_LO/TS_HI as above.
// - Macro undefined: no counter/shadow flops; TS_LO/TS_HI still decoded.
// - Macro undefined: TS offsets read 0, writes ignored; window size unchanged.
// TESTING
// - Reset then read offset 0..NumRwRegs+2 -> bus_data_o = 0 one cycle after each pulse.
// - Write 32'hDEAD_BEEF to BaseAddress+1 -> rw_regs_o reg1 = DEAD_BEEF, wr_strobe_o = 4'b0010 for 1 clk; readback DEAD_BEEF.
// - Pulse event_i = 8'h05, write 32'h01 to STATUS -> flags 8'h04.
// - STATUS write 32'h04 with event_i[2]=1 same cycle -> flag 2 stays set.
// - TIMESTAMP_EN: force counter 64'h0000_0001_FFFF_FFFF, read TS_LO, wait 10 clks, read TS_HI.
//   -> TS_LO = FFFF_FFFF, TS_HI = 1 (shadow, not 2); wrap 64'hFFFF..FF -> 0.
// - Read BaseAddress+NumRwRegs+3 (out of window) -> no writes, bus_data_o unchanged.
// - Assert reset_n_i mid-read -> bus_data_o = 0 immediately, all outputs reset; next read ok.
// - Macro undefined: TS_LO read -> 0.

Source files
------------

// File: rtl/cdc_dst_reg_bank.sv
// cdc_dst_reg_bank: register bank slave for one bus_cdc destination domain (RW regs, W1C event flags, timestamp).
// Optional 64-bit timestamp counter and TS_HI shadow are built only when CDC_DST_REG_BANK_TIMESTAMP_EN is defined.
module cdc_dst_reg_bank #(
    parameter logic [31:0] BaseAddress  = 32'h0000_9000,
    parameter int          AddressWidth = 32,
    parameter int          DataWidth    = 32,
    parameter int          NumRwRegs    = 4,
    parameter int          NumEvents    = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           bus_we_i,
    input  logic [AddressWidth-1:0]        bus_address_i,
    input  logic [DataWidth-1:0]           bus_data_i,
    output logic [DataWidth-1:0]           bus_data_o,
    input  logic [NumEvents-1:0]           event_i,
    output logic [NumRwRegs*DataWidth-1:0] rw_regs_o,
    output logic [NumRwRegs-1:0]           wr_strobe_o,
    output logic [NumEvents-1:0]           event_flags_o
);
    localparam int NumRegs = NumRwRegs + 3;
    localparam logic [AddressWidth-1:0] Base = AddressWidth'(BaseAddress);

    logic [AddressWidth-1:0] offset;
    logic                    in_win, rd, wr, sel_status;
    logic [DataWidth-1:0]    rd_data;
    logic [DataWidth-1:0]    bus_data_q, bus_data_d;
    logic [DataWidth-1:0]    rw_q [NumRwRegs];
    logic [DataWidth-1:0]    rw_d [NumRwRegs];
    logic [NumRwRegs-1:0]    strobe_q, strobe_d;
    logic [NumEvents-1:0]    flags_q, flags_d;

    // Address 0 marks an idle bus; BaseAddress is nonzero so idle never decodes.
    assign offset     = bus_address_i - Base;
    assign in_win     = (bus_address_i >= Base) && (offset < AddressWidth'(NumRegs));
    assign rd         = in_win && !bus_we_i;
    assign wr         = in_win && bus_we_i;
    assign sel_status = offset == AddressWidth'(NumRwRegs);

`ifdef CDC_DST_REG_BANK_TIMESTAMP_EN
    logic        sel_lo, sel_hi;
    logic [63:0] cnt_q, cnt_d;
    logic [31:0] shadow_q, shadow_d;

    assign sel_lo = offset == AddressWidth'(NumRwRegs + 1);
    assign sel_hi = offset == AddressWidth'(NumRwRegs + 2);

    // Timestamp halves are 32 bits; narrower buses see the low bits, wider ones zero-extended.
    function automatic logic [DataWidth-1:0] fit(input logic [31:0] v);
        logic [DataWidth+31:0] t;
        t = {{DataWidth{1'b0}}, v};
        return t[DataWidth-1:0];
    endfunction

    // A clearing write beats the free-running increment.
    assign cnt_d    = (wr && sel_lo) ? 64'd0 : cnt_q + 64'd1;
    assign shadow_d = (rd && sel_lo) ? cnt_q[63:32] : shadow_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NumRwRegs; k++)
            if (offset == AddressWidth'(k)) rd_data = rw_q[k];
        if (sel_status) rd_data = DataWidth'(flags_q);
`ifdef CDC_DST_REG_BANK_TIMESTAMP_EN
        if (sel_lo) rd_data = fit(cnt_q[31:0]);
        if (sel_hi) rd_data = fit(shadow_q);
`endif
    end

    assign bus_data_d = rd ? rd_data : bus_data_q;

    // Set wins over W1C clear when an event arrives in the clearing cycle.
    assign flags_d = ((wr && sel_status) ? (flags_q & ~bus_data_i[NumEvents-1:0]) : flags_q) | event_i;

    always_comb begin
        strobe_d = '0;
        for (int k = 0; k < NumRwRegs; k++) begin
            rw_d[k]     = rw_q[k];
            strobe_d[k] = wr && (offset == AddressWidth'(k));
            if (strobe_d[k]) rw_d[k] = bus_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            bus_data_q <= '0;
            strobe_q   <= '0;
            flags_q    <= '0;
            for (int k = 0; k < NumRwRegs; k++) rw_q[k] <= '0;
        end else begin
            bus_data_q <= bus_data_d;
            strobe_q   <= strobe_d;
            flags_q    <= flags_d;
            for (int k = 0; k < NumRwRegs; k++) rw_q[k] <= rw_d[k];
        end
    end

    always_comb begin
        rw_regs_o = '0;
        for (int k = 0; k < NumRwRegs; k++) rw_regs_o[k*DataWidth +: DataWidth] = rw_q[k];
    end

    assign bus_data_o    = bus_data_q;
    assign wr_strobe_o   = strobe_q;
    assign event_flags_o = flags_q;
endmodule

// File: tb/tb_cdc_dst_reg_bank.sv
// tb_cdc_dst_reg_bank: directed checks of decode, RW strobes, W1C flags, timestamp and async reset.
module tb_cdc_dst_reg_bank;
    localparam logic [31:0] B = 32'h0000_9000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic [7:0]   ev;
    logic [127:0] rw_regs;
    logic [3:0]   strobe;
    logic [7:0]   flags;
    int           checks = 0;
    int           errors = 0;

    cdc_dst_reg_bank dut (
        .clk_i(clk), .reset_n_i(rst_n), .bus_we_i(we), .bus_address_i(addr),
        .bus_data_i(wdata), .bus_data_o(rdata), .event_i(ev), .rw_regs_o(rw_regs),
        .wr_strobe_o(strobe), .event_flags_o(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        we = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0; addr = '0; wdata = '0;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; addr = '0; wdata = '0; ev = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdata", rdata, 0);
        chk("reset_rw", rw_regs, 0);
        chk("reset_strobe", strobe, 0);
        chk("reset_flags", flags, 0);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef CDC_DST_REG_BANK_TIMESTAMP_EN
        for (int i = 0; i < 5; i++) begin
`else
        for (int i = 0; i < 7; i++) begin
`endif
            access(1'b0, B + i, 0);
            chk($sformatf("read_after_reset_%0d", i), rdata, 0);
        end

        access(1'b1, B + 1, 32'hDEAD_BEEF);
        chk("reg1_write", rw_regs[63:32], 32'hDEAD_BEEF);
        chk("strobe_reg1", strobe, 4'b0010);
        @(posedge clk);
        #1;
        chk("strobe_drop", strobe, 4'b0000);
        access(1'b0, B + 1, 0);
        chk("reg1_readback", rdata, 32'hDEAD_BEEF);

        access(1'b1, B + 0, 32'h1234_5678);
        chk("strobe_reg0", strobe, 4'b0001);
        access(1'b1, B + 3, 32'hCAFE_F00D);
        chk("strobe_reg3", strobe, 4'b1000);
        access(1'b0, B + 3, 0);
        chk("reg3_readback", rdata, 32'hCAFE_F00D);

        access(1'b1, B + 7, 32'hFFFF_FFFF);
        chk("oow_write_strobe", strobe, 0);
        access(1'b1, B - 1, 32'hFFFF_FFFF);
        chk("below_write_rw", rw_regs, {32'hCAFE_F00D, 32'h0, 32'hDEAD_BEEF, 32'h1234_5678});
        access(1'b0, B + 7, 0);
        chk("oow_read_hold", rdata, 32'hCAFE_F00D);

        @(negedge clk);
        ev = 8'h05;
        @(posedge clk);
        #1;
        ev = 8'h00;
        chk("event_set", flags, 8'h05);
        access(1'b1, B + 4, 32'h1);
        chk("w1c_bit0", flags, 8'h04);
        @(negedge clk);
        we = 1'b1; addr = B + 4; wdata = 32'h4; ev = 8'h04;
        @(posedge clk);
        #1;
        we = 1'b0; addr = '0; wdata = '0; ev = '0;
        chk("set_wins", flags, 8'h04);
        access(1'b0, B + 4, 0);
        chk("status_read", rdata, 32'h4);
        access(1'b1, B + 4, 32'h4);
        chk("w1c_bit2", flags, 8'h00);

        access(1'b0, B + 0, 0);
        chk("b2b_first", rdata, 32'h1234_5678);
        access(1'b0, B + 1, 0);
        chk("b2b_second", rdata, 32'hDEAD_BEEF);

`ifdef CDC_DST_REG_BANK_TIMESTAMP_EN
        access(1'b1, B + 5, 32'hFFFF_FFFF);
        repeat (3) @(posedge clk);
        access(1'b0, B + 5, 0);
        chk("ts_after_clear", rdata, 32'd3);
        access(1'b0, B + 6, 0);
        chk("ts_hi_after_clear", rdata, 0);
        @(negedge clk);
        force dut.cnt_q = 64'h0000_0001_FFFF_FFFF;
        #1;
        release dut.cnt_q;
        addr = B + 5;
        @(posedge clk);
        #1;
        addr = '0;
        chk("ts_lo_snap", rdata, 32'hFFFF_FFFF);
        repeat (10) @(posedge clk);
        access(1'b0, B + 6, 0);
        chk("ts_hi_shadow", rdata, 32'h1);
        @(negedge clk);
        force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.cnt_q;
        addr = B + 5;
        @(posedge clk);
        #1;
        addr = '0;
        chk("ts_lo_max", rdata, 32'hFFFF_FFFF);
        access(1'b0, B + 5, 0);
        chk("ts_lo_wrap", rdata, 0);
        access(1'b0, B + 6, 0);
        chk("ts_hi_wrap", rdata, 0);
`else
        access(1'b1, B + 5, 32'hFFFF_FFFF);
        chk("ts_write_rw", rw_regs, {32'hCAFE_F00D, 32'h0, 32'hDEAD_BEEF, 32'h1234_5678});
        access(1'b0, B + 5, 0);
        chk("ts_lo_zero", rdata, 0);
        access(1'b0, B + 1, 0);
        access(1'b0, B + 6, 0);
        chk("ts_hi_zero", rdata, 0);
`endif

        access(1'b0, B + 1, 0);
        chk("pre_reset_read", rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        addr = B + 1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_rdata", rdata, 0);
        chk("midreset_rw", rw_regs, 0);
        chk("midreset_flags", flags, 0);
        @(posedge clk);
        #1;
        addr = '0;
        chk("midreset_dropped", rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b1, B + 2, 32'hA5A5_5A5A);
        chk("post_reset_strobe", strobe, 4'b0100);
        access(1'b0, B + 2, 0);
        chk("post_reset_read", rdata, 32'hA5A5_5A5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
